// File: rtl/seg_scan_sched.sv
// seg_scan_sched: 6-digit 7-seg buffer, round-robin A/B write port, blanked digit scan; SEG_DP_EN adds dp_in.
// Writes ack one cycle after grant; an acked port sits out one cycle; all outputs registered.
module seg_scan_sched #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 64,
  parameter int BLANK_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [2:0]        addr_a,
  input  logic [3:0]        data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [2:0]        addr_b,
  input  logic [3:0]        data_b,
  output logic              ack_b,
  input  logic [DIGITS-1:0] en_mask,
`ifdef SEG_DP_EN
  input  logic [DIGITS-1:0] dp_in,
`endif
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        dig,
  output logic              frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [3:0]      buffer [DIGITS];
  logic [3:0]      nibble, nibble_n;
  logic            dp, dp_n;
  logic            wrap;
  logic            ptr_b;
  logic            el_a, el_b, gnt_a, gnt_b;
  logic [DIGITS-1:0] sel_n;
  logic [7:0]      dig_n;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // A port acked this cycle is still seeing its ack, so it must not be granted again.
  assign el_a  = req_a & ~ack_a;
  assign el_b  = req_b & ~ack_b;
  assign gnt_a = el_a & (~el_b | ~ptr_b);
  assign gnt_b = el_b & (~el_a |  ptr_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      ptr_b <= 1'b0;
      for (int i = 0; i < DIGITS; i++) buffer[i] <= 4'h0;
    end else begin
      ack_a <= gnt_a;
      ack_b <= gnt_b;
      if (el_a && el_b) ptr_b <= gnt_a;
      if (gnt_a && addr_a <= LAST_IDX) buffer[addr_a] <= data_a;
      if (gnt_b && addr_b <= LAST_IDX) buffer[addr_b] <= data_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= BLANK;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    idx_n    = idx;
    nibble_n = nibble;
    dp_n     = dp;
    wrap     = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          state_n  = DRIVE;
          nibble_n = buffer[idx];
`ifdef SEG_DP_EN
          dp_n     = dp_in[idx];
`endif
        end
      end
      default: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          state_n = BLANK;
          cnt_n   = '0;
          wrap    = (idx == LAST_IDX);
          idx_n   = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
        end
      end
    endcase

    // Outputs are registered, so they are computed from the post-edge state.
    sel_n = '1;
    dig_n = 8'hFF;
    if (state_n == DRIVE) begin
      dig_n = {~dp_n, seg7(nibble_n)};
      for (int i = 0; i < DIGITS; i++)
        if (idx_n == 3'(i) && en_mask[i]) sel_n[DIGITS-1-i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 3'd0;
      nibble     <= 4'h0;
      dp         <= 1'b0;
      sel        <= '1;
      dig        <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      nibble     <= nibble_n;
      dp         <= dp_n;
      sel        <= sel_n;
      dig        <= dig_n;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched: handshake sequences, a table of scan-frame vectors, reset mid-slot.
module tb_seg_scan_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] addr_a = 3'd0, addr_b = 3'd0;
  logic [3:0] data_a = 4'h0, data_b = 4'h0;
  logic       ack_a, ack_b;
  logic [5:0] en_mask = 6'h3F;
  logic [5:0] sel;
  logic [7:0] dig;
  logic       frame_tick;
`ifdef SEG_DP_EN
  logic [5:0] dp_in = 6'h00;
`endif

  int total = 0;
  int bad   = 0;

  seg_scan_sched dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
    .en_mask(en_mask),
`ifdef SEG_DP_EN
    .dp_in(dp_in),
`endif
    .sel(sel), .dig(dig), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         adv;
    logic [5:0] mask;
    logic [5:0] sel;
    logic [7:0] dig;
    logic       ft;
  } vec_t;

  vec_t vt [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_acks(input string name, input logic ea, input logic eb);
    chk({name, "_ack_a"}, {31'd0, ack_a}, {31'd0, ea});
    chk({name, "_ack_b"}, {31'd0, ack_b}, {31'd0, eb});
  endtask

  initial begin
    bit seen;

    // Buffer after the write phase: d0..d5 = 1,2,5,8,A,F.
    // Positions below are offsets into a frame, starting at digit0 cnt0.
    vt[0]  = '{1,  6'h3F, 6'h3F, 8'hFF, 1'b0}; // f=1   blank, no tick
    vt[1]  = '{3,  6'h3F, 6'h1F, 8'hF9, 1'b0}; // f=4   d0 first drive
    vt[2]  = '{59, 6'h3F, 6'h1F, 8'hF9, 1'b0}; // f=63  d0 last drive
    vt[3]  = '{1,  6'h3F, 6'h3F, 8'hFF, 1'b0}; // f=64  d1 blank
    vt[4]  = '{3,  6'h3F, 6'h3F, 8'hFF, 1'b0}; // f=67  d1 last blank
    vt[5]  = '{1,  6'h3F, 6'h2F, 8'hA4, 1'b0}; // f=68  d1 drive
    vt[6]  = '{64, 6'h3B, 6'h3F, 8'h92, 1'b0}; // f=132 d2 masked off
    vt[7]  = '{1,  6'h3F, 6'h37, 8'h92, 1'b0}; // f=133 d2 re-enabled mid-slot
    vt[8]  = '{64, 6'h3F, 6'h3B, 8'h80, 1'b0}; // f=197 d3
    vt[9]  = '{64, 6'h3F, 6'h3D, 8'h88, 1'b0}; // f=261 d4
    vt[10] = '{64, 6'h1F, 6'h3F, 8'h8E, 1'b0}; // f=325 d5 masked off
    vt[11] = '{1,  6'h3F, 6'h3E, 8'h8E, 1'b0}; // f=326 d5 enabled
    vt[12] = '{57, 6'h3F, 6'h3E, 8'h8E, 1'b0}; // f=383 last cycle of frame
    vt[13] = '{1,  6'h3F, 6'h3F, 8'hFF, 1'b1}; // f=384 wrap: tick
    vt[14] = '{1,  6'h3F, 6'h3F, 8'hFF, 1'b0}; // f=385 tick is one cycle

    // Reset held three cycles.
    repeat (3) tick();
    chk("rst_sel", {26'd0, sel}, 32'h3F);
    chk("rst_dig", {24'd0, dig}, 32'hFF);
    chk_acks("rst", 1'b0, 1'b0);
    chk("rst_ft", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("blank_cnt3_dig", {24'd0, dig}, 32'hFF);
    tick();
    chk("first_drive_dig", {24'd0, dig}, 32'hC0);
    chk("first_drive_sel", {26'd0, sel}, 32'h1F);

    // Single write on A: ack exactly one cycle later, one cycle wide.
    req_a = 1'b1; addr_a = 3'd2; data_a = 4'h5;
    tick(); chk_acks("wr_a", 1'b1, 1'b0);
    req_a = 1'b0;
    tick(); chk_acks("wr_a_done", 1'b0, 1'b0);

    // Collision with pointer on A: A then B.
    req_a = 1'b1; addr_a = 3'd0; data_a = 4'h1;
    req_b = 1'b1; addr_b = 3'd1; data_b = 4'h2;
    tick(); chk_acks("col1_first", 1'b1, 1'b0);
    req_a = 1'b0;
    tick(); chk_acks("col1_second", 1'b0, 1'b1);
    req_b = 1'b0;
    tick(); chk_acks("col1_idle", 1'b0, 1'b0);

    // Next collision: pointer now favours B.
    req_a = 1'b1; addr_a = 3'd3; data_a = 4'h8;
    req_b = 1'b1; addr_b = 3'd4; data_b = 4'hA;
    tick(); chk_acks("col2_first", 1'b0, 1'b1);
    req_b = 1'b0;
    tick(); chk_acks("col2_second", 1'b1, 1'b0);
    req_a = 1'b0;
    tick(); chk_acks("col2_idle", 1'b0, 1'b0);

    // Out-of-range address is acked but discarded.
    req_b = 1'b1; addr_b = 3'd7; data_b = 4'h3;
    tick(); chk_acks("oob_b", 1'b0, 1'b1);
    req_b = 1'b0;
    tick();
    req_a = 1'b1; addr_a = 3'd5; data_a = 4'hF;
    tick(); chk_acks("wr_d5", 1'b1, 1'b0);
    req_a = 1'b0;
    tick();

    // Align to a frame start.
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick();
      if (frame_tick) seen = 1'b1;
    end
    chk("frame_align", {31'd0, seen}, 32'd1);

    for (int v = 0; v < 15; v++) begin
      en_mask = vt[v].mask;
      repeat (vt[v].adv) tick();
      chk($sformatf("vec%0d_sel", v), {26'd0, sel}, {26'd0, vt[v].sel});
      chk($sformatf("vec%0d_dig", v), {24'd0, dig}, {24'd0, vt[v].dig});
      chk($sformatf("vec%0d_ft", v), {31'd0, frame_tick}, {31'd0, vt[v].ft});
    end

    // Reset mid-DRIVE with a request held: no ack, everything back to reset.
    repeat (10) tick();
    chk("pre_rst_dig", {24'd0, dig}, 32'hF9);
    rst = 1'b1; req_a = 1'b1; addr_a = 3'd1; data_a = 4'h7;
    tick();
    chk_acks("midrst", 1'b0, 1'b0);
    chk("midrst_sel", {26'd0, sel}, 32'h3F);
    chk("midrst_dig", {24'd0, dig}, 32'hFF);
    chk("midrst_ft", {31'd0, frame_tick}, 32'd0);
    tick();
    chk_acks("midrst_hold", 1'b0, 1'b0);
    rst = 1'b0; req_a = 1'b0;
    repeat (4) tick();
    chk("rst_d0_dig", {24'd0, dig}, 32'hC0);
    chk("rst_d0_sel", {26'd0, sel}, 32'h1F);
    repeat (64) tick();
    chk("rst_d1_dig", {24'd0, dig}, 32'hC0);
    chk("rst_d1_sel", {26'd0, sel}, 32'h2F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
